systolic_result_drain: RTL and testbench
========================================

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16, operand width; result element width is 2*DATAWIDTH.
REQ-002 SHALL have parameter N_SIZE, default 5, matrix dimension (N_SIZE >= 2).
REQ-003 SHALL have clk, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have row_valid, input, 1, one result row of matrix C present (connects to the array's valid_out).
REQ-006 SHALL have row_data, input, N_SIZE x 2*DATAWIDTH unpacked array, row elements, index k = column k.
REQ-007 SHALL have m_valid, output, 1, stream element valid.
REQ-008 SHALL have m_ready, input, 1, downstream accepts element.
REQ-009 SHALL have m_data, output, 2*DATAWIDTH, element C[r][c].
REQ-010 SHALL have m_row and m_col, outputs, $clog2(N_SIZE) each, indices r and c of m_data.
REQ-011 SHALL have m_last, output, 1, high with element C[N_SIZE-1][N_SIZE-1].
REQ-012 SHALL have overflow, output, 1, sticky row-drop flag.
REQ-013 SHALL have ovf_clr, input, 1, synchronous clear of overflow.

Function
REQ-014 SHALL hold two N_SIZE x N_SIZE banks (ping-pong); each bank is EMPTY, FILLING or FULL.
REQ-015 SHALL, on each edge with row_valid=1 and write bank not FULL, store row_data at row wr_row of write bank and increment wr_row.
REQ-016 SHALL, when row N_SIZE-1 is stored, mark write bank FULL, reset wr_row to 0, toggle write pointer on the same edge.
REQ-017 SHALL allow row_valid gaps inside a matrix; wr_row holds across gaps.
REQ-018 SHALL, when row_valid=1 and write bank FULL, drop the row, set overflow, and drop all further rows until row_valid has been sampled 0 (burst discard), even if a bank frees mid-burst.
REQ-019 SHALL have drain FSM states DRAIN_IDLE and DRAIN_STREAM; IDLE->STREAM when read bank FULL; STREAM->IDLE on acceptance of m_last when other bank not FULL.
REQ-020 SHALL emit read bank in row-major order, one element per accepted transfer (m_valid & m_ready).
REQ-021 SHALL raise m_valid with C[0][0] on the first edge after the edge storing row N_SIZE-1 (1-cycle latency) when FSM was IDLE.
REQ-022 SHALL hold m_data, m_row, m_col, m_last stable while m_valid=1 and m_ready=0.
REQ-023 SHALL sustain one element per cycle with m_ready=1, including zero-bubble transition into the other bank if it is FULL when m_last is accepted.
REQ-024 SHALL mark read bank EMPTY and toggle read pointer on the edge accepting m_last.
REQ-025 SHALL allow a row write and an m_last acceptance on the same edge; a bank freed on that edge accepts rows from the next edge.
REQ-026 SHALL give ovf_clr priority under simultaneous set: overflow clears, new drops on later edges set it again.
REQ-027 SHALL perform no arithmetic on data; element width preserved, no truncation.

Reset
REQ-028 SHALL on rst_n=0 force: both banks EMPTY, pointers 0, wr_row 0, FSM DRAIN_IDLE, discard flag 0, m_valid 0, m_data 0, m_row 0, m_col 0, m_last 0, overflow 0.
REQ-029 SHALL not reset bank storage contents.
REQ-030 SHALL discard any partially filled matrix on reset mid-operation; first post-reset row is row 0.

Structure
REQ-031 SHALL take from shared package systolic_pkg: default DATAWIDTH/N_SIZE constants, result element typedef (2*DATAWIDTH), drain_state_t enum, bank_state_t enum.
REQ-032 SHALL instantiate sub-module systolic_result_bank twice (one N_SIZE x N_SIZE store, row write port, element read port); control stays in top.

Verification (DATAWIDTH=16, N_SIZE=5)
REQ-033 SHALL test: 5 rows, C[r][c]=r*16+c, m_ready=1 -> m_valid one edge after row 4, 25 elements 0x00..0x44 in order, m_last only on 0x44.
REQ-034 SHALL test: m_ready toggled 1010..., -> no loss/duplication, m_data stable on stalled cycles, 25 transfers.
REQ-035 SHALL test: two back-to-back 5-row matrices, m_ready=1 -> 50 consecutive m_valid cycles, no bubble at matrix boundary.
REQ-036 SHALL test: m_ready=0, three 5-row matrices separated by 1-cycle gaps -> first two stored, third dropped whole, overflow=1; ovf_clr=1 one cycle -> overflow=0.
REQ-037 SHALL test: rst_n asserted after row 2 of a matrix -> all outputs at reset values; next 5 rows form a complete matrix streamed correctly.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result path.
// Holds the default operand width and matrix size, the result element type
// (twice the operand width) and the state encodings used by the drain logic.
package systolic_pkg;

  localparam int DEF_DATAWIDTH = 16;
  localparam int DEF_N_SIZE    = 5;

  // One element of result matrix C at the default operand width.
  typedef logic [2*DEF_DATAWIDTH-1:0] result_t;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_state_t;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_STREAM
  } drain_state_t;

endpackage

// File: rtl/systolic_result_bank.sv
// One N_SIZE x N_SIZE result matrix store.
// Ports:
//   clk        - clock
//   wr_en_i    - write a whole row on this edge
//   wr_row_i   - row index written
//   wr_data_i  - row elements, index k = column k
//   rd_row_i   - row index of the element read
//   rd_col_i   - column index of the element read
//   rd_data_o  - element at (rd_row_i, rd_col_i), combinational
// Storage is deliberately not reset; the bank state in the top decides
// whether its contents are meaningful.
module systolic_result_bank
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int N_SIZE    = DEF_N_SIZE
) (
  input  logic                        clk,
  input  logic                        wr_en_i,
  input  logic [$clog2(N_SIZE)-1:0]   wr_row_i,
  input  logic [2*DATAWIDTH-1:0]      wr_data_i [0:N_SIZE-1],
  input  logic [$clog2(N_SIZE)-1:0]   rd_row_i,
  input  logic [$clog2(N_SIZE)-1:0]   rd_col_i,
  output logic [2*DATAWIDTH-1:0]      rd_data_o
);

  logic [2*DATAWIDTH-1:0] mem_q [0:N_SIZE-1][0:N_SIZE-1];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int k = 0; k < N_SIZE; k++) begin
        mem_q[wr_row_i][k] <= wr_data_i[k];
      end
    end
  end

  assign rd_data_o = mem_q[rd_row_i][rd_col_i];

endmodule

// File: rtl/systolic_result_drain.sv
// Collects result rows of matrix C from a systolic array into two ping-pong
// banks and streams each completed matrix out element by element, row-major,
// on a valid/ready interface.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   row_valid/row_data - one result row per valid cycle (index k = column k)
//   m_valid/m_ready    - output handshake
//   m_data/m_row/m_col - element C[r][c] and its indices
//   m_last             - marks C[N_SIZE-1][N_SIZE-1]
//   overflow/ovf_clr   - sticky row-drop flag and its synchronous clear
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int N_SIZE    = DEF_N_SIZE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        row_valid,
  input  logic [2*DATAWIDTH-1:0]      row_data [0:N_SIZE-1],
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [2*DATAWIDTH-1:0]      m_data,
  output logic [$clog2(N_SIZE)-1:0]   m_row,
  output logic [$clog2(N_SIZE)-1:0]   m_col,
  output logic                        m_last,
  output logic                        overflow,
  input  logic                        ovf_clr
);

  localparam int RW = 2*DATAWIDTH;
  localparam int IW = $clog2(N_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SIZE-1);

  bank_state_t  bank_st_q [2];
  bank_state_t  bank_st_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] wr_row_q, wr_row_d;
  logic         discard_q, discard_d;
  drain_state_t state_q, state_d;
  logic [RW-1:0] m_data_q, m_data_d;
  logic [IW-1:0] m_row_q, m_row_d;
  logic [IW-1:0] m_col_q, m_col_d;
  logic         m_last_q, m_last_d;
  logic         overflow_q, overflow_d;

  logic          wr_full, row_acc, row_drop;
  logic          rd_free, load;
  logic          rd_bank;
  logic [IW-1:0] rd_r, rd_c;
  logic [RW-1:0] rd_data [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    systolic_result_bank #(
      .DATAWIDTH (DATAWIDTH),
      .N_SIZE    (N_SIZE)
    ) u_bank (
      .clk       (clk),
      .wr_en_i   (row_acc && (wr_ptr_q == 1'(b))),
      .wr_row_i  (wr_row_q),
      .wr_data_i (row_data),
      .rd_row_i  (rd_r),
      .rd_col_i  (rd_c),
      .rd_data_o (rd_data[b])
    );
  end

  // Drain FSM: chooses which element is loaded into the output register next.
  // The address is looked ahead so the element is registered on the edge the
  // previous one is accepted, giving one transfer per cycle.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rd_free  = 1'b0;
    load     = 1'b0;
    rd_bank  = rd_ptr_q;
    rd_r     = '0;
    rd_c     = '0;
    case (state_q)
      DRAIN_IDLE: begin
        if (bank_st_q[rd_ptr_q] == BANK_FULL) begin
          state_d = DRAIN_STREAM;
          load    = 1'b1;
        end
      end
      DRAIN_STREAM: begin
        if (m_ready) begin
          if (m_last_q) begin
            rd_free  = 1'b1;
            rd_ptr_d = !rd_ptr_q;
            // Chain straight into the other bank when it is already full.
            if (bank_st_q[!rd_ptr_q] == BANK_FULL) begin
              load    = 1'b1;
              rd_bank = !rd_ptr_q;
            end else begin
              state_d = DRAIN_IDLE;
            end
          end else begin
            load = 1'b1;
            if (m_col_q == LAST_IDX) begin
              rd_r = m_row_q + IW'(1);
              rd_c = '0;
            end else begin
              rd_r = m_row_q;
              rd_c = m_col_q + IW'(1);
            end
          end
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  // Write side. Once a row hits a full bank, the rest of that row_valid burst
  // is discarded even if a bank frees up mid-burst, so a matrix is never
  // assembled from the tail of a truncated one.
  always_comb begin
    bank_st_d  = bank_st_q;
    wr_ptr_d   = wr_ptr_q;
    wr_row_d   = wr_row_q;
    wr_full    = (bank_st_q[wr_ptr_q] == BANK_FULL);
    row_acc    = row_valid && !discard_q && !wr_full;
    row_drop   = row_valid && !row_acc;
    discard_d  = row_valid && (discard_q || wr_full);
    overflow_d = ovf_clr ? 1'b0 : (overflow_q || row_drop);
    // A freed bank is always FULL beforehand, so it never collides with the
    // bank being written below.
    if (rd_free) begin
      bank_st_d[rd_ptr_q] = BANK_EMPTY;
    end
    if (row_acc) begin
      if (wr_row_q == LAST_IDX) begin
        bank_st_d[wr_ptr_q] = BANK_FULL;
        wr_row_d            = '0;
        wr_ptr_d            = !wr_ptr_q;
      end else begin
        bank_st_d[wr_ptr_q] = BANK_FILLING;
        wr_row_d            = wr_row_q + IW'(1);
      end
    end
  end

  // Output register: loads only on a new element, so it holds under stall.
  always_comb begin
    m_data_d = m_data_q;
    m_row_d  = m_row_q;
    m_col_d  = m_col_q;
    m_last_d = m_last_q;
    if (load) begin
      m_data_d = rd_data[rd_bank];
      m_row_d  = rd_r;
      m_col_d  = rd_c;
      m_last_d = (rd_r == LAST_IDX) && (rd_c == LAST_IDX);
    end else if (state_d == DRAIN_IDLE) begin
      m_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_row_q     <= '0;
      discard_q    <= 1'b0;
      state_q      <= DRAIN_IDLE;
      m_data_q     <= '0;
      m_row_q      <= '0;
      m_col_q      <= '0;
      m_last_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      bank_st_q    <= bank_st_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_row_q     <= wr_row_d;
      discard_q    <= discard_d;
      state_q      <= state_d;
      m_data_q     <= m_data_d;
      m_row_q      <= m_row_d;
      m_col_q      <= m_col_d;
      m_last_q     <= m_last_d;
      overflow_q   <= overflow_d;
    end
  end

  assign m_valid  = (state_q == DRAIN_STREAM);
  assign m_data   = m_data_q;
  assign m_row    = m_row_q;
  assign m_col    = m_col_q;
  assign m_last   = m_last_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain (DATAWIDTH=16, N_SIZE=5). A behavioural
// model tracks whole matrices: rows accumulate into a pending matrix, a
// completed matrix becomes 25 expected elements in a queue, and a row is
// dropped whenever two completed matrices are still undelivered.
module tb_systolic_result_drain;
  import systolic_pkg::*;

  localparam int N  = 5;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          row_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  result_t       row_data [0:N-1];
  logic          m_valid, m_last, overflow;
  result_t       m_data;
  logic [IW-1:0] m_row, m_col;

  always #5 clk = ~clk;

  systolic_result_drain #(.DATAWIDTH(16), .N_SIZE(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_valid (row_valid),
    .row_data  (row_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_row     (m_row),
    .m_col     (m_col),
    .m_last    (m_last),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    result_t d;
    int      r;
    int      c;
    bit      last;
  } el_t;

  el_t     exp_q [$];
  result_t part [N][N];
  int      part_rows = 0;
  int      full_cnt = 0;
  bit      discard = 0;
  bit      exp_ovf = 0;
  int      xfers = 0;
  int      run = 0;
  int      max_run = 0;
  bit      tog = 0;
  bit      prev_stall = 0;
  result_t prev_d;
  int      prev_r, prev_c;
  bit      prev_l;

  function automatic bit pick_rdy(input int mode);
    bit v;
    case (mode)
      0: v = 1'b0;
      1: v = 1'b1;
      2: begin v = tog; tog = ~tog; end
      default: v = 1'($urandom_range(0, 1));
    endcase
    return v;
  endfunction

  // One clock cycle: apply inputs, check outputs against the model, advance
  // the model across the coming edge, then wait until just after that edge.
  task automatic cyc(input bit rv, input bit rdy, input bit clr);
    el_t e;
    bit  dec;
    bit  drop;
    row_valid = rv;
    m_ready   = rdy;
    ovf_clr   = clr;
    check_eq("overflow", overflow, exp_ovf);
    if (m_valid) run++; else run = 0;
    if (run > max_run) max_run = run;
    if (prev_stall) begin
      check_eq("stall_valid", m_valid, 1);
      check_eq("stall_data", m_data, prev_d);
      check_eq("stall_row", m_row, prev_r);
      check_eq("stall_col", m_col, prev_c);
      check_eq("stall_last", m_last, prev_l);
    end
    dec  = 0;
    drop = 0;
    if (m_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", m_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("m_data", m_data, e.d);
        check_eq("m_row", m_row, e.r);
        check_eq("m_col", m_col, e.c);
        check_eq("m_last", m_last, e.last);
        dec = e.last;
        xfers++;
      end
    end
    prev_stall = m_valid && !rdy;
    prev_d = m_data;
    prev_r = int'(m_row);
    prev_c = int'(m_col);
    prev_l = m_last;
    if (rv) begin
      if (discard || full_cnt == 2) begin
        discard = 1;
        drop    = 1;
      end else begin
        for (int c = 0; c < N; c++) part[part_rows][c] = row_data[c];
        part_rows++;
        if (part_rows == N) begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              e.d = part[r][c];
              e.r = r;
              e.c = c;
              e.last = (r == N-1) && (c == N-1);
              exp_q.push_back(e);
            end
          end
          full_cnt++;
          part_rows = 0;
        end
      end
    end else begin
      discard = 0;
    end
    exp_ovf = clr ? 1'b0 : (exp_ovf | drop);
    if (dec) full_cnt--;
    @(posedge clk);
    #1;
  endtask

  task automatic send_matrix(input bit rnd, input int rdy_mode);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) row_data[c] = rnd ? result_t'($urandom) : result_t'(r*16 + c);
      cyc(1, pick_rdy(rdy_mode), 0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 2000) begin
      cyc(0, 1, 0);
      n++;
    end
    check_eq("drain_idle", m_valid, 0);
    check_eq("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    row_valid = 1'b0;
    m_ready   = 1'b0;
    ovf_clr   = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_data", m_data, 0);
    check_eq("rst_row", m_row, 0);
    check_eq("rst_col", m_col, 0);
    check_eq("rst_last", m_last, 0);
    check_eq("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    exp_q.delete();
    full_cnt   = 0;
    part_rows  = 0;
    discard    = 0;
    exp_ovf    = 0;
    prev_stall = 0;
    run        = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < N; c++) row_data[c] = '0;
    do_reset();

    // Pattern matrix, free-running sink: latency and ordering.
    xfers = 0;
    send_matrix(0, 1);
    check_eq("lat_early", m_valid, 0);
    cyc(0, 1, 0);
    check_eq("lat_valid", m_valid, 1);
    check_eq("first_data", m_data, 0);
    drain();
    check_eq("t033_xfers", xfers, 25);

    // Alternating ready.
    xfers = 0;
    tog = 1;
    send_matrix(1, 2);
    for (int i = 0; i < 80 && (exp_q.size() != 0 || m_valid); i++) cyc(0, pick_rdy(2), 0);
    check_eq("t034_xfers", xfers, 25);
    drain();

    // Two back-to-back matrices: 50 consecutive valid cycles.
    xfers = 0;
    max_run = 0;
    send_matrix(1, 1);
    send_matrix(1, 1);
    drain();
    check_eq("t035_run", max_run, 50);
    check_eq("t035_xfers", xfers, 50);

    // Stalled sink, three matrices: the third is dropped whole.
    xfers = 0;
    send_matrix(1, 0);
    cyc(0, 0, 0);
    send_matrix(1, 0);
    cyc(0, 0, 0);
    send_matrix(1, 0);
    cyc(0, 0, 0);
    check_eq("t036_ovf_set", overflow, 1);
    cyc(0, 0, 1);
    check_eq("t036_ovf_clr", overflow, 0);
    drain();
    check_eq("t036_xfers", xfers, 50);

    // Reset mid-operation while a matrix is stalled and another is partial.
    send_matrix(1, 0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < N; c++) row_data[c] = result_t'($urandom);
      cyc(1, 0, 0);
    end
    do_reset();
    xfers = 0;
    send_matrix(1, 1);
    drain();
    check_eq("t037_xfers", xfers, 25);

    // Random traffic, backpressure and clears.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) row_data[c] = result_t'($urandom);
      cyc($urandom_range(0, 3) != 0, pick_rdy(3), $urandom_range(0, 47) == 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
